// File: rtl/dram_mux_bank_if.sv
// Request/grant bus between the requester channels and dram_mux_bank.
// Channel i occupies bit i of the per-channel vectors and slice i of the packed
// address/data vectors.
//   req, write_en        : per-channel request and access type (1 = write)
//   address, data        : per-channel address and write data
//   gnt                  : one-hot grant, combinational
//   q, rvalid            : per-channel read holding registers and update strobe
//   busy                 : OR of all requests
interface dram_mux_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16
) ();

  logic [CHANNELS-1:0]        req;
  logic [CHANNELS-1:0]        write_en;
  logic [CHANNELS*ADDR_W-1:0] address;
  logic [CHANNELS*DATA_W-1:0] data;
  logic [CHANNELS-1:0]        gnt;
  logic [CHANNELS*DATA_W-1:0] q;
  logic [CHANNELS-1:0]        rvalid;
  logic                       busy;

  // Requester side.
  modport master (
    output req, write_en, address, data,
    input  gnt, q, rvalid, busy
  );

  // Memory front-end side.
  modport slave (
    input  req, write_en, address, data,
    output gnt, q, rvalid, busy
  );

endinterface

// File: rtl/dram_mux_bank.sv
// Round-robin shared single-port RAM front end for CHANNELS requesters.
// One grant per cycle; the winner's write lands on the grant edge, a read is
// captured by the RAM on the grant edge and copied into that channel's q slice
// on the following edge together with a one-cycle rvalid pulse.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (RAM contents are not cleared)
//   bus   : dram_mux_bank_if slave port (req/write_en/address/data in,
//           gnt/q/rvalid/busy out)
module dram_mux_bank #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CHANNELS = 4
) (
  input logic            clk,
  input logic            rst_n,
  dram_mux_bank_if.slave bus
);

  localparam int unsigned PtrW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [PtrW-1:0]            ptr_q, ptr_d;
  logic [PtrW-1:0]            win_idx;
  logic                       win_vld;
  int unsigned                cand;
  logic [CHANNELS-1:0]        gnt;

  logic [ADDR_W-1:0]          sel_addr;
  logic [DATA_W-1:0]          sel_data;
  logic                       sel_we;

  logic [DATA_W-1:0]          mem [Depth];
  logic [DATA_W-1:0]          rd_data_q;
  logic                       rd_pend_q;
  logic [PtrW-1:0]            rd_tag_q;
  logic [CHANNELS*DATA_W-1:0] q_q;
  logic [CHANNELS-1:0]        rvalid_q;

  // Search from the pointer, wrapping, first requester wins. Nothing is
  // granted while reset is asserted so no write can slip through.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = PtrW'(cand);
      end
    end
    if (!rst_n) win_vld = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (win_vld) gnt[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) begin
      ptr_d = (win_idx == PtrW'(CHANNELS - 1)) ? '0 : win_idx + PtrW'(1);
    end
  end

  assign sel_addr = bus.address[win_idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.data[win_idx*DATA_W +: DATA_W];
  assign sel_we   = bus.write_en[win_idx];

  // Plain synchronous-read RAM: no reset so it maps onto block memory.
  // A write followed by a read of the same word on the next edge sees new data.
  always_ff @(posedge clk) begin
    if (win_vld && sel_we)  mem[sel_addr] <= sel_data;
    if (win_vld && !sel_we) rd_data_q     <= mem[sel_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= '0;
      q_q       <= '0;
      rvalid_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= win_vld && !sel_we;
      if (win_vld) rd_tag_q <= win_idx;
      rvalid_q  <= '0;
      // Completing read from the previous grant; dropped if reset intervenes.
      if (rd_pend_q) begin
        q_q[rd_tag_q*DATA_W +: DATA_W] <= rd_data_q;
        rvalid_q[rd_tag_q]             <= 1'b1;
      end
    end
  end

  assign bus.gnt    = gnt;
  assign bus.q      = q_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = |bus.req;

endmodule

// File: tb/tb_dram_mux_bank.sv
// Directed bench for dram_mux_bank with four 16-bit channels and 8-bit address.
module tb_dram_mux_bank;

  localparam int unsigned Ch = 4;
  localparam int unsigned Aw = 8;
  localparam int unsigned Dw = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dram_mux_bank_if #(.CHANNELS(Ch), .ADDR_W(Aw), .DATA_W(Dw)) bus ();

  dram_mux_bank #(.DATA_W(Dw), .ADDR_W(Aw), .CHANNELS(Ch)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [Aw-1:0] a,
                        input logic [Dw-1:0] d);
    bus.write_en[ch]          = we;
    bus.address[ch*Aw +: Aw]  = a;
    bus.data[ch*Dw +: Dw]     = d;
  endtask

  initial begin
    logic [3:0] e;
    int         c;

    // Reset held two cycles with every channel trying to write 0xDEAD.
    rst_n       = 1'b0;
    bus.req     = '1;
    bus.write_en = '1;
    bus.address = '0;
    bus.data    = '0;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'h05, 16'hDEAD);
    #1;
    chk("rst_gnt_comb", bus.gnt, 4'b0);
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'b0);
    chk("rst_rvalid", bus.rvalid, 4'b0);
    chk("rst_q", bus.q, 64'h0);

    // ch0 write 0x1234 @0x05, then read it back.
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    set_ch(0, 1'b1, 8'h05, 16'h1234);
    #1;
    chk("wr0_gnt", bus.gnt, 4'b0001);
    chk("busy_hi", bus.busy, 1'b1);
    tick();
    set_ch(0, 1'b0, 8'h05, 16'h0000);
    #1;
    chk("rd0_gnt", bus.gnt, 4'b0001);
    tick();
    bus.req = 4'b0000;
    #1;
    chk("busy_lo", bus.busy, 1'b0);
    chk("rd0_not_yet", bus.rvalid, 4'b0);
    tick();
    chk("rd0_rvalid", bus.rvalid, 4'b0001);
    chk("rd0_q", bus.q[15:0], 16'h1234);
    tick();
    chk("rd0_rvalid_pulse", bus.rvalid, 4'b0);
    chk("rd0_q_hold", bus.q[15:0], 16'h1234);

    // Preload 0x10..0x13 with 0xA0..0xA3 through ch3, leaving the pointer at 0.
    for (int i = 0; i < 4; i++) begin
      bus.req = 4'b1000;
      set_ch(3, 1'b1, 8'(8'h10 + i), 16'(16'hA0 + i));
      #1;
      chk("pre_gnt", bus.gnt, 4'b1000);
      tick();
    end

    // All four channels read continuously: grants rotate 0,1,2,3,...
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 8'(8'h10 + i), 16'h0);
    for (int n = 0; n < 10; n++) begin
      if (n == 8) bus.req = 4'b0000;
      #1;
      e = (n < 8) ? (4'b0001 << (n % 4)) : 4'b0000;
      chk("rr_gnt", bus.gnt, e);
      if (n >= 2) begin
        c = (n - 2) % 4;
        chk("rr_rvalid", bus.rvalid, 4'b0001 << c);
        chk("rr_q", bus.q[c*Dw +: Dw], 16'(16'hA0 + c));
      end else begin
        chk("rr_rvalid_idle", bus.rvalid, 4'b0);
      end
      tick();
    end
    chk("rr_rvalid_drain", bus.rvalid, 4'b0);
    chk("rr_q_all", bus.q, 64'h00A3_00A2_00A1_00A0);

    // Pointer fairness: after ch2 wins, ch3 beats ch1.
    bus.req = 4'b0100;
    #1;
    chk("fair_g2", bus.gnt, 4'b0100);
    tick();
    bus.req = 4'b1010;
    #1;
    chk("fair_g3", bus.gnt, 4'b1000);
    tick();
    bus.req = 4'b0010;
    #1;
    chk("fair_g1", bus.gnt, 4'b0010);
    tick();
    bus.req = 4'b0000;
    tick();
    tick();

    // RAW across channels: ch1 writes 0xBEEF @0x20, ch3 reads it next cycle.
    bus.req = 4'b0010;
    set_ch(1, 1'b1, 8'h20, 16'hBEEF);
    #1;
    chk("raw_wr_gnt", bus.gnt, 4'b0010);
    tick();
    bus.req = 4'b1000;
    set_ch(3, 1'b0, 8'h20, 16'h0);
    #1;
    chk("raw_rd_gnt", bus.gnt, 4'b1000);
    tick();
    bus.req = 4'b0000;
    #1;
    chk("raw_not_yet", bus.rvalid, 4'b0);
    tick();
    chk("raw_rvalid", bus.rvalid, 4'b1000);
    chk("raw_q3", bus.q[3*Dw +: Dw], 16'hBEEF);

    // Reset right after a ch2 read grant; writes attempted during reset.
    tick();
    bus.req = 4'b0100;
    set_ch(2, 1'b0, 8'h20, 16'h0);
    #1;
    chk("mid_gnt", bus.gnt, 4'b0100);
    tick();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'h20, 16'hDEAD);
    #1;
    chk("mid_rst_gnt", bus.gnt, 4'b0);
    tick();
    chk("mid_rvalid0", bus.rvalid, 4'b0);
    chk("mid_q_clr", bus.q, 64'h0);
    tick();
    chk("mid_rvalid1", bus.rvalid, 4'b0);
    chk("mid_q2", bus.q[2*Dw +: Dw], 16'h0);

    // Retry after release: data must still be 0xBEEF.
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 8'h20, 16'h0);
    #1;
    chk("retry_gnt", bus.gnt, 4'b0100);
    tick();
    bus.req = 4'b0000;
    #1;
    chk("retry_not_yet", bus.rvalid, 4'b0);
    tick();
    chk("retry_rvalid", bus.rvalid, 4'b0100);
    chk("retry_q2", bus.q[2*Dw +: Dw], 16'hBEEF);
    chk("retry_q_others", bus.q & ~(64'hFFFF << 32), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_mux_bank.md
Name: dram_mux_bank

Overview:
- Parametrised successor to the two-channel time-sliced DRAM front end.
- Shares one single-port RAM across CHANNELS independent requesters using round-robin arbitration and a per-channel req/gnt handshake.
- Returns read data on per-channel holding registers with a valid strobe.
- Sits between the matrix-multiply operand fetch/store engines and operand storage; replaces fixed slot enables with demand-driven access.

Parameters:
- DATA_W, 16, word width of RAM and all data ports
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W words
- CHANNELS, 4, number of requester channels (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  CHANNELS  per-channel access request, bit i = channel i
- write_en  in  CHANNELS  per-channel access type: 1 = write, 0 = read; sampled with req
- address  in  CHANNELS*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
- data  in  CHANNELS*DATA_W  per-channel write data, channel i at [i*DATA_W +: DATA_W]
- gnt  out  CHANNELS  one-hot (or zero) grant, combinational from req and the priority pointer
- q  out  CHANNELS*DATA_W  per-channel read-data holding registers
- rvalid  out  CHANNELS  one-cycle pulse: q slice i updated this cycle
- busy  out  1  OR of req (combinational)

Behaviour:
- Reset (rst_n=0 at a clk edge): priority pointer = 0; all q = 0; rvalid = 0; in-flight read tag cleared. RAM contents are not reset.
- Arbitration: each cycle at most one grant. Search channels starting at pointer, wrapping modulo CHANNELS; the first with req=1 wins. gnt = 0 when no req or when rst_n=0.
- Pointer update: on any grant to channel k, pointer <= (k+1) mod CHANNELS. With no grant, pointer holds.
- Handshake: a requester holds req, write_en, address and data stable until it sees gnt[i]=1 in the same cycle. The transfer occurs on that edge. The requester may drop req or present a new request in the next cycle. Back-to-back grants to one channel are allowed only when no other channel is requesting.
- Write: on the grant edge, RAM[address_k] <= data_k. No rvalid is produced.
- Read: on the grant edge, the RAM registers the address and the block records tag k. On the next edge, q slice k <= RAM data and rvalid[k]=1 for exactly that cycle. Latency is 1 cycle from grant edge to q update. Other q slices hold their values; q slice k holds until channel k's next read completes.
- Pipelining: a new grant may issue every cycle. Reads from different channels complete in grant order, one per cycle.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data. Same-cycle conflict is impossible because only one grant is issued per cycle.
- Starvation bound: a continuously requesting channel is granted within CHANNELS cycles.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no rvalid, and q stays 0. A write on an edge where rst_n=0 is not performed.
- Address range: full 2**ADDR_W words with no wrap logic; the address is used directly.
- CHANNELS=1: pointer is constant 0 and gnt = req.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req=1 -> gnt=0, rvalid=0, all q=0, no RAM writes occur.
- Write/read single channel: ch0 writes 0x1234 to addr 0x05, then reads addr 0x05 -> gnt[0] on each request; one cycle after the read grant, q0=0x1234, rvalid[0]=1 for one cycle; q0 holds afterwards.
- Round-robin: channels 0–3 all hold read req continuously at addrs 0x10–0x13 (preloaded 0xA0–0xA3) -> grant order 0,1,2,3,0…; q_i=0xA0+i, each rvalid pulses once per 4 cycles.
- Pointer fairness: after a grant to ch2, ch1 and ch3 request simultaneously -> ch3 is granted first, then ch1.
- RAW across channels: ch1 writes 0xBEEF to 0x20; ch3 reads 0x20 in the next cycle -> q3=0xBEEF with rvalid[3]=1 one cycle after ch3's grant.
- Reset mid-read: ch2 read granted, rst_n=0 on the following edge -> rvalid[2] never pulses and q2=0; after release, ch2's retried read returns the correct data.
